// File: rtl/bcd_pkg.sv
// Shared BCD types, constants and the load-value clamp helper.
package bcd_pkg;

  localparam int unsigned BCD_W = 4;
  localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;

  typedef logic [BCD_W-1:0] bcd_digit_t;

  // Saturate a nibble to a legal BCD code so non-BCD values never reach a digit register.
  function automatic bcd_digit_t bcd_clamp(input bcd_digit_t nibble);
    return (nibble > BCD_MAX) ? BCD_MAX : nibble;
  endfunction

endpackage

// File: rtl/bcd_counter_8d_if.sv
// Control, load and display bus of the BCD counter.
interface bcd_counter_8d_if #(
  parameter int unsigned NUM_DIGITS = 8
);
  logic                    en;
  logic                    up;
  logic                    clear;
  logic                    load;
  logic [4*NUM_DIGITS-1:0] load_val;
  logic [4*NUM_DIGITS-1:0] digits;
  logic                    tick;
  logic                    wrap;

  modport master (
    output en, up, clear, load, load_val,
    input  digits, tick, wrap
  );

  modport slave (
    input  en, up, clear, load, load_val,
    output digits, tick, wrap
  );
endinterface

// File: rtl/bcd_digit_cell.sv
// One BCD digit: clear > load > carry/borrow-enabled step, with ripple carry/borrow out.
module bcd_digit_cell
  import bcd_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear_i,
  input  logic       load_i,
  input  bcd_digit_t load_val_i,
  input  logic       step_i,
  input  logic       up_i,
  input  logic       cin_i,
  output logic       cout_o,
  output bcd_digit_t q_o
);

  bcd_digit_t q_q, q_d;

  // Carry (up) or borrow (down) propagates only when this digit rolls over.
  always_comb begin
    cout_o = cin_i & (up_i ? (q_q == BCD_MAX) : (q_q == '0));
  end

  // Next digit value by priority.
  always_comb begin
    q_d = q_q;
    if (clear_i) begin
      q_d = '0;
    end else if (load_i) begin
      q_d = bcd_clamp(load_val_i);
    end else if (step_i && cin_i) begin
      if (up_i) q_d = (q_q == BCD_MAX) ? bcd_digit_t'(0) : q_q + 4'd1;
      else      q_d = (q_q == '0)      ? BCD_MAX          : q_q - 4'd1;
    end
  end

  // Digit register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q_q <= '0;
    else        q_q <= q_d;
  end

  assign q_o = q_q;

endmodule

// File: rtl/bcd_counter_8d.sv
// Eight-digit packed-BCD up/down counter with free-running tick prescaler.
module bcd_counter_8d
  import bcd_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 50_000_000,
  parameter int unsigned TICK_HZ    = 1,
  parameter int unsigned NUM_DIGITS = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  bcd_counter_8d_if.slave   bus
);

  localparam int unsigned DIV   = CLK_HZ / TICK_HZ;
  localparam int unsigned CNT_W = (DIV > 2) ? $clog2(DIV) : 1;

  logic [CNT_W-1:0] pre_cnt_q, pre_cnt_d;
  logic             tick_q, tick_d;
  logic             wrap_q, wrap_d;
  logic             term;
  logic             step;
  logic             top_carry;
  logic [4*NUM_DIGITS-1:0] digits_w;

  assign term = (pre_cnt_q == CNT_W'(DIV - 1));
  // A load or clear on the same edge swallows the step, so no wrap can come from it.
  assign step = term & bus.en & ~bus.clear & ~bus.load;

  // Prescaler next state and registered pulse sources.
  always_comb begin
    pre_cnt_d = pre_cnt_q + 1'b1;
    if (bus.clear || term) pre_cnt_d = '0;
    tick_d = term & ~bus.clear;
    wrap_d = step & top_carry;
  end

  // Prescaler, tick and wrap registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_cnt_q <= '0;
      tick_q    <= 1'b0;
      wrap_q    <= 1'b0;
    end else begin
      pre_cnt_q <= pre_cnt_d;
      tick_q    <= tick_d;
      wrap_q    <= wrap_d;
    end
  end

  // Per-block carry nets keep the ripple chain free of self-referencing vectors.
  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_dig
    logic       cin;
    logic       co;
    bcd_digit_t q;

    if (i == 0) begin : g_first
      assign cin = 1'b1;
    end else begin : g_rest
      assign cin = g_dig[i-1].co;
    end

    bcd_digit_cell u_cell (
      .clk        (clk),
      .rst_n      (rst_n),
      .clear_i    (bus.clear),
      .load_i     (bus.load),
      .load_val_i (bus.load_val[4*i +: 4]),
      .step_i     (step),
      .up_i       (bus.up),
      .cin_i      (cin),
      .cout_o     (co),
      .q_o        (q)
    );

    assign digits_w[4*i +: 4] = q;
  end

  assign top_carry  = g_dig[NUM_DIGITS-1].co;
  assign bus.digits = digits_w;
  assign bus.tick   = tick_q;
  assign bus.wrap   = wrap_q;

endmodule
